// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the pipeline WB stage
// and a multiply/divide unit (MDU). The MDU result is captured in a one-entry
// buffer and written back on a cycle where the pipeline does not write. A
// pipeline write to the same register discards the buffered value, because
// the pipeline result is program-later.
//
// Optional feature (macro WB_ARB_STARVE_EN):
//   When defined, a starvation counter tracks how long the buffered result
//   has been blocked by pipeline writes. Once it reaches STARVE_LIMIT, the
//   arbiter spends one FORCE cycle with StallPipe high, giving the port to
//   the buffer. When undefined, the counter and FORCE state do not exist and
//   StallPipe is tied low.
//
// Parameters:
//   STARVE_LIMIT  blocked FULL cycles before FORCE (1..15, default 4)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   RegWriteW  in   pipeline WB write request
//   WriteRegW  in   pipeline WB destination register [4:0]
//   ResultW    in   pipeline WB write data [31:0]
//   MduValid   in   MDU offers a result
//   MduReg     in   MDU destination register [4:0]
//   MduData    in   MDU result data [31:0]
//   MduReady   out  arbiter accepts an MDU result this cycle
//   RfWe       out  register-file write enable
//   RfWa       out  register-file write address [4:0]
//   RfWd       out  register-file write data [31:0]
//   StallPipe  out  freezes the IF..MEM/WB pipeline registers
//   PendValid  out  an MDU result is buffered and not yet written
//   PendReg    out  destination of the buffered result [4:0]
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  input  logic        MduValid,
  input  logic [4:0]  MduReg,
  input  logic [31:0] MduData,
  output logic        MduReady,
  output logic        RfWe,
  output logic [4:0]  RfWa,
  output logic [31:0] RfWd,
  output logic        StallPipe,
  output logic        PendValid,
  output logic [4:0]  PendReg
);

`ifdef WB_ARB_STARVE_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    FORCE = 2'd2
  } arbState_e;
`else
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1
  } arbState_e;
`endif

  arbState_e   state;
  logic [4:0]  pendRegR;
  logic [31:0] pendDataR;
  logic        mduReadyR;
  logic        pendValidR;
  logic        pipeWr;
  logic        pendHit;

`ifdef WB_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] waitCntR;
  logic       stallR;
`else
  // The limit only matters with the starvation logic built in.
  logic unusedStarveLimit;
  assign unusedStarveLimit = (STARVE_LIMIT == 32'd0);
`endif

  // Register $0 is hard-wired zero, so a write to it is no write at all.
  assign pipeWr  = RegWriteW && (WriteRegW != 5'd0);
  // A program-later pipeline write to the buffered register supersedes it.
  assign pendHit = pipeWr && (WriteRegW == pendRegR);

  // Write-port mux: the pipeline has priority except in FORCE.
  always_comb begin
    RfWe = 1'b0;
    RfWa = 5'd0;
    RfWd = 32'd0;
    case (state)
      EMPTY: begin
        if (pipeWr) begin
          RfWe = 1'b1;
          RfWa = WriteRegW;
          RfWd = ResultW;
        end else begin
          RfWe = 1'b0;
        end
      end
      FULL: begin
        if (pipeWr) begin
          RfWe = 1'b1;
          RfWa = WriteRegW;
          RfWd = ResultW;
        end else begin
          // Drain; a result destined for $0 is consumed without a write.
          RfWe = (pendRegR != 5'd0);
          RfWa = pendRegR;
          RfWd = pendDataR;
        end
      end
`ifdef WB_ARB_STARVE_EN
      FORCE: begin
        // Pipeline is frozen and will re-present its write next cycle.
        RfWe = (pendRegR != 5'd0);
        RfWa = pendRegR;
        RfWd = pendDataR;
      end
`endif
      default: begin
        RfWe = 1'b0;
      end
    endcase
  end

  // Buffer FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      pendRegR   <= 5'd0;
      pendDataR  <= 32'd0;
      mduReadyR  <= 1'b1;
      pendValidR <= 1'b0;
`ifdef WB_ARB_STARVE_EN
      waitCntR   <= 4'd0;
      stallR     <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (MduValid) begin
            state      <= FULL;
            pendRegR   <= MduReg;
            pendDataR  <= MduData;
            mduReadyR  <= 1'b0;
            pendValidR <= 1'b1;
`ifdef WB_ARB_STARVE_EN
            waitCntR   <= 4'd0;
`endif
          end
        end
        FULL: begin
          if (!pipeWr || pendHit) begin
            // Drained this cycle, or superseded by the pipeline write.
            state      <= EMPTY;
            mduReadyR  <= 1'b1;
            pendValidR <= 1'b0;
          end else begin
`ifdef WB_ARB_STARVE_EN
            // Blocked by an unrelated pipeline write.
            if ((waitCntR + 4'd1) == LIMIT) begin
              state    <= FORCE;
              stallR   <= 1'b1;
            end
            waitCntR   <= waitCntR + 4'd1;
`endif
          end
        end
`ifdef WB_ARB_STARVE_EN
        FORCE: begin
          state      <= EMPTY;
          stallR     <= 1'b0;
          mduReadyR  <= 1'b1;
          pendValidR <= 1'b0;
          waitCntR   <= 4'd0;
        end
`endif
        default: begin
          state      <= EMPTY;
          mduReadyR  <= 1'b1;
          pendValidR <= 1'b0;
`ifdef WB_ARB_STARVE_EN
          stallR     <= 1'b0;
          waitCntR   <= 4'd0;
`endif
        end
      endcase
    end
  end

  assign MduReady  = mduReadyR;
  assign PendValid = pendValidR;
  assign PendReg   = pendRegR;
`ifdef WB_ARB_STARVE_EN
  assign StallPipe = stallR;
`else
  assign StallPipe = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed scenarios followed by random traffic, checked against a
// queue-based model of the shared write port. Build with or without
// WB_ARB_STARVE_EN; the model and the starvation scenarios follow the macro.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  WriteRegW = 5'd0;
  logic [31:0] ResultW = 32'd0;
  logic        MduValid = 1'b0;
  logic [4:0]  MduReg = 5'd0;
  logic [31:0] MduData = 32'd0;
  logic        MduReady;
  logic        RfWe;
  logic [4:0]  RfWa;
  logic [31:0] RfWd;
  logic        StallPipe;
  logic        PendValid;
  logic [4:0]  PendReg;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .MduValid(MduValid), .MduReg(MduReg), .MduData(MduData),
    .MduReady(MduReady), .RfWe(RfWe), .RfWa(RfWa), .RfWd(RfWd),
    .StallPipe(StallPipe), .PendValid(PendValid), .PendReg(PendReg)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: pending MDU results as a queue (at most one entry),
  // how many cycles the entry has been blocked, and a one-shot force flag.
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } pend_t;
  pend_t pendQ[$];
  int    waited = 0;
  bit    inForce = 1'b0;

  // Observed values from the most recent cycle, for directed checks.
  logic        lastWe, lastStall, lastPv, lastReady;
  logic [4:0]  lastWa;
  logic [31:0] lastWd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pendQ.delete();
    waited  = 0;
    inForce = 1'b0;
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic cycle(input logic rw, input logic [4:0] wr, input logic [31:0] res,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bit          pipeWr, eWe, eReady, ePv;
    logic [4:0]  eWa;
    logic [31:0] eWd;
    RegWriteW = rw; WriteRegW = wr; ResultW = res;
    MduValid = mv;  MduReg = mr;    MduData = md;
    pipeWr = rw && (wr != 5'd0);
    eReady = (pendQ.size() == 0);
    ePv    = (pendQ.size() != 0);
    eWa = 5'd0; eWd = 32'd0; eWe = 1'b0;
    if (inForce || (ePv && !pipeWr)) begin
      eWe = (pendQ[0].r != 5'd0); eWa = pendQ[0].r; eWd = pendQ[0].d;
    end else if (pipeWr) begin
      eWe = 1'b1; eWa = wr; eWd = res;
    end
    @(negedge clk);
    lastWe = RfWe; lastWa = RfWa; lastWd = RfWd;
    lastStall = StallPipe; lastPv = PendValid; lastReady = MduReady;
    chk("MduReady", MduReady, eReady);
    chk("StallPipe", StallPipe, inForce);
    chk("PendValid", PendValid, ePv);
    chk("RfWe", RfWe, eWe);
    if (eWe) begin
      chk("RfWa", RfWa, eWa);
      chk("RfWd", RfWd, eWd);
    end
    if (ePv) chk("PendReg", PendReg, pendQ[0].r);
    @(posedge clk);
    if (inForce) begin
      void'(pendQ.pop_front());
      inForce = 1'b0;
    end else if (pendQ.size() == 0) begin
      if (mv) begin
        pendQ.push_back('{r: mr, d: md});
        waited = 0;
      end
    end else if (!pipeWr || wr == pendQ[0].r) begin
      void'(pendQ.pop_front());
    end else begin
      waited++;
      if (STARVE_EN && waited >= LIMIT) inForce = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    // Reset state
    modelReset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_StallPipe", StallPipe, 1'b0);
    chk("rst_PendValid", PendValid, 1'b0);
    chk("rst_RfWe", RfWe, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle();
    chk("ready_after_reset", lastReady, 1'b1);

    // MDU result captured, then drained while MduValid is still high
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
    chk("drain_we", lastWe, 1'b1);
    chk("drain_wa", lastWa, 5'd5);
    chk("drain_wd", lastWd, 32'h0000_1234);
    chk("drain_not_ready", lastReady, 1'b0);
    idle();
    chk("empty_after_drain", lastPv, 1'b0);
    chk("ready_after_drain", lastReady, 1'b1);

    // Same-register pipeline write supersedes the buffered value
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_AAAA);
    cycle(1'b1, 5'd9, 32'h0000_BBBB, 1'b0, 5'd0, 32'd0);
    chk("discard_wd", lastWd, 32'h0000_BBBB);
    chk("discard_wa", lastWa, 5'd9);
    idle();
    chk("discard_pv", lastPv, 1'b0);

    // Result for $0 is consumed without a write
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    idle();
    chk("r0_no_write", lastWe, 1'b0);
    idle();

    // Pipeline writes with $0 as destination are suppressed
    cycle(1'b1, 5'd0, 32'h1111_1111, 1'b0, 5'd0, 32'd0);
    chk("pipe_r0_no_write", lastWe, 1'b0);

`ifdef WB_ARB_STARVE_EN
    // Starvation: four pipeline writes, a one-cycle force, then the retry
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_7777);
    for (int i = 0; i < LIMIT; i++) begin
      cycle(1'b1, 5'd3, 32'h0000_0333, 1'b0, 5'd0, 32'd0);
      chk("starve_wa", lastWa, 5'd3);
      chk("starve_nostall", lastStall, 1'b0);
    end
    cycle(1'b1, 5'd3, 32'h0000_0333, 1'b0, 5'd0, 32'd0);
    chk("force_stall", lastStall, 1'b1);
    chk("force_wa", lastWa, 5'd7);
    chk("force_wd", lastWd, 32'h0000_7777);
    cycle(1'b1, 5'd3, 32'h0000_0333, 1'b0, 5'd0, 32'd0);
    chk("retry_stall", lastStall, 1'b0);
    chk("retry_wa", lastWa, 5'd3);
    idle();

    // Reset during FORCE drops StallPipe and the buffer without a clock edge
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_7777);
    for (int i = 0; i < LIMIT; i++) cycle(1'b1, 5'd3, 32'h0000_0333, 1'b0, 5'd0, 32'd0);
    #1;
    chk("pre_reset_stall", StallPipe, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_stall", StallPipe, 1'b0);
    chk("async_pv", PendValid, 1'b0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle();
    chk("ready_after_force_reset", lastReady, 1'b1);
`else
    // Without starvation logic the buffer simply waits
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0000_6666);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 5'd4, 32'h0000_0444, 1'b0, 5'd0, 32'd0);
      chk("nostarve_stall", lastStall, 1'b0);
      chk("nostarve_pv", lastPv, 1'b1);
    end
    idle();
    chk("late_drain_wa", lastWa, 5'd6);
    chk("late_drain_wd", lastWd, 32'h0000_6666);
`endif

    // Random traffic; small register range to hit same-register cases
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0,
            5'($urandom_range(0, 7)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
